rpsc_interlock_seq: RTL and testbench

RPSC_INTERLOCK_SEQ -- requirements
Module: rpsc_interlock_seq

---
 rtl/rpsc_pkg.sv | 17 +
 rtl/rpsc_delay_cnt.sv | 25 ++
 rtl/rpsc_interlock_seq.sv | 97 +++++++++
 tb/tb_rpsc_interlock_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rpsc_pkg.sv
// Shared state encoding and default delay constants for the interlock sequencer.
package rpsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_TRIP   = 3'd4
  } rpsc_state_t;

  localparam int DEF_N_STATUS   = 7;
  localparam int DEF_DLY_W      = 22;
  localparam int DEF_RAMP_CYC   = 3125000;
  localparam int DEF_SETTLE_CYC = 46875000;

endpackage

// File: rtl/rpsc_delay_cnt.sv
// Up-counter with synchronous load-to-zero; stops at term so it can never wrap.
module rpsc_delay_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == term);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rpsc_interlock_seq.sv
// Cathode/anode supply interlock: permission check, timed RAMP/SETTLE sequencing,
// fault trip with first-cause capture and operator-acknowledged recovery.
module rpsc_interlock_seq
  import rpsc_pkg::*;
#(
  parameter int N_STATUS   = DEF_N_STATUS,
  parameter int DLY_W      = DEF_DLY_W,
  parameter int RAMP_CYC   = DEF_RAMP_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_STATUS-1:0]   status_i,
  input  logic                  g1_ok_i,
  input  logic                  fan_on_i,
  input  logic                  ca_req_i,
  input  logic                  i_high_i,
  input  logic                  u_low_i,
  input  logic                  fault_clr_i,
  output logic                  ca_perm_o,
  output logic                  ca_on_o,
  output logic                  ca_ok_o,
  output logic                  trip_o,
  output logic [N_STATUS+1:0]   first_fault_o,
  output logic                  i_high_o,
  output logic                  u_low_o,
  output logic [2:0]            state_o
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (DLY_W > SET_W) ? DLY_W : SET_W;
  localparam int FF_W  = N_STATUS + 2;
  localparam logic [CNT_W-1:0] RAMP_TC   = CNT_W'(RAMP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYC - 1);
  localparam logic [FF_W-1:0]  FF_ONE    = FF_W'(1);

  rpsc_state_t       state, nxt;
  logic              perm, active, qual, tc, cnt_en, cnt_load;
  logic [CNT_W-1:0]  term;
  logic [FF_W-1:0]   cause;

  assign perm   = ~|status_i & g1_ok_i & fan_on_i;
  assign active = (state == ST_RAMP) || (state == ST_SETTLE) || (state == ST_RUN);
  assign qual   = (state == ST_SETTLE) || (state == ST_RUN);
  assign cnt_en = (state == ST_RAMP) || (state == ST_SETTLE);
  assign term   = (state == ST_SETTLE) ? SETTLE_TC : RAMP_TC;
  // Any state change restarts the shared counter, so SETTLE begins from 0.
  assign cnt_load = (nxt != state) || !cnt_en;
  assign cause    = {u_low_o, i_high_o, status_i};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (ca_req_i && perm) nxt = ST_RAMP;
      ST_RAMP, ST_SETTLE, ST_RUN: begin
        if (!perm)                             nxt = ST_TRIP;
        else if (qual && (i_high_i || u_low_i)) nxt = ST_TRIP;
        else if (!ca_req_i)                    nxt = ST_IDLE;
        else if (state == ST_RAMP && tc)       nxt = ST_SETTLE;
        else if (state == ST_SETTLE && tc)     nxt = ST_RUN;
      end
      ST_TRIP: if (fault_clr_i && perm && !ca_req_i) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  rpsc_delay_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .term  (term),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      first_fault_o <= '0;
    end else begin
      state <= nxt;
      // Lowest set bit wins; a supply/fan-only trip leaves cause empty.
      if (nxt == ST_TRIP && state != ST_TRIP) begin
        first_fault_o <= cause & (~cause + FF_ONE);
      end
    end
  end

  assign ca_perm_o = perm;
  assign ca_on_o   = active;
  assign ca_ok_o   = (state == ST_RUN);
  assign trip_o    = (state == ST_TRIP);
  assign i_high_o  = i_high_i & qual;
  assign u_low_o   = u_low_i & qual;
  assign state_o   = state;

endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Directed bench for rpsc_interlock_seq with short ramp/settle delays.
module tb_rpsc_interlock_seq;

  localparam int NS = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] status_i;
  logic          g1_ok_i, fan_on_i, ca_req_i, i_high_i, u_low_i, fault_clr_i;
  logic          ca_perm_o, ca_on_o, ca_ok_o, trip_o, i_high_o, u_low_o;
  logic [NS+1:0] first_fault_o;
  logic [2:0]    state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rpsc_interlock_seq #(
    .N_STATUS(NS), .DLY_W(22), .RAMP_CYC(4), .SETTLE_CYC(6)
  ) u_dut (
    .clk(clk), .reset(reset), .status_i(status_i), .g1_ok_i(g1_ok_i),
    .fan_on_i(fan_on_i), .ca_req_i(ca_req_i), .i_high_i(i_high_i),
    .u_low_i(u_low_i), .fault_clr_i(fault_clr_i), .ca_perm_o(ca_perm_o),
    .ca_on_o(ca_on_o), .ca_ok_o(ca_ok_o), .trip_o(trip_o),
    .first_fault_o(first_fault_o), .i_high_o(i_high_o), .u_low_o(u_low_o),
    .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
  endtask

  task automatic go_run();
    ca_req_i = 1'b1;
    repeat (11) step();
  endtask

  initial begin
    reset = 1'b1; status_i = '0; g1_ok_i = 1'b1; fan_on_i = 1'b1;
    ca_req_i = 1'b0; i_high_i = 1'b0; u_low_i = 1'b0; fault_clr_i = 1'b0;
    step(); step();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outs", {29'd0, ca_on_o, ca_ok_o, trip_o}, 32'd0);
    chk("rst_ff", 32'(first_fault_o), 32'd0);
    chk("rst_perm", 32'(ca_perm_o), 32'd1);
    reset = 1'b0;
    step();

    // Startup timing, with an i_high blip during RAMP that must be ignored
    ca_req_i = 1'b1;
    step();
    chk("ramp_on", 32'(ca_on_o), 32'd1);
    chk("ramp_state", 32'(state_o), 32'd1);
    i_high_i = 1'b1;
    #1;
    chk("ramp_ihigh_o", 32'(i_high_o), 32'd0);
    for (int c = 2; c <= 11; c++) begin
      step();
      if (c == 2) begin
        chk("ramp_ihigh_notrip", 32'(trip_o), 32'd0);
        i_high_i = 1'b0;
      end
      if (c == 4)  chk("ramp_last", 32'(state_o), 32'd1);
      if (c == 5)  chk("settle_entry", 32'(state_o), 32'd2);
      if (c == 10) chk("ok_not_yet", 32'(ca_ok_o), 32'd0);
    end
    chk("ok_at_11", 32'(ca_ok_o), 32'd1);
    chk("run_state", 32'(state_o), 32'd3);

    // Drop request in RUN: clean shutdown
    ca_req_i = 1'b0;
    step();
    chk("drop_idle", 32'(state_o), 32'd0);
    chk("drop_notrip", 32'(trip_o), 32'd0);

    // Status fault in SETTLE cycle 2
    ca_req_i = 1'b1;
    repeat (6) step();
    chk("settle2_state", 32'(state_o), 32'd2);
    status_i[3] = 1'b1;
    #1;
    chk("perm_low", 32'(ca_perm_o), 32'd0);
    step();
    chk("st3_trip", 32'(trip_o), 32'd1);
    chk("st3_ff", 32'(first_fault_o), 32'h008);
    chk("st3_on", 32'(ca_on_o), 32'd0);
    clr_pulse();
    chk("clr_blocked", 32'(state_o), 32'd4);
    status_i = '0;
    clr_pulse();
    chk("clr_blocked_req", 32'(state_o), 32'd4);
    ca_req_i = 1'b0;
    step();
    chk("trip_held", 32'(state_o), 32'd4);
    clr_pulse();
    chk("clr_idle", 32'(state_o), 32'd0);
    chk("ff_retained", 32'(first_fault_o), 32'h008);

    // i_high in RUN
    go_run();
    chk("run2", 32'(ca_ok_o), 32'd1);
    i_high_i = 1'b1;
    #1;
    chk("run_ihigh_o", 32'(i_high_o), 32'd1);
    step();
    chk("ihigh_trip", 32'(trip_o), 32'd1);
    chk("ihigh_ff", 32'(first_fault_o), 32'h080);
    i_high_i = 1'b0; ca_req_i = 1'b0;
    clr_pulse();
    chk("ihigh_clr", 32'(state_o), 32'd0);

    // Two status bits rise together in RUN: lowest index wins
    go_run();
    status_i = 7'b0100010;
    step();
    chk("dual_trip", 32'(trip_o), 32'd1);
    chk("dual_ff", 32'(first_fault_o), 32'h002);
    status_i = '0; ca_req_i = 1'b0;
    clr_pulse();

    // u_low in RUN
    go_run();
    u_low_i = 1'b1;
    step();
    chk("ulow_ff", 32'(first_fault_o), 32'h100);
    u_low_i = 1'b0; ca_req_i = 1'b0;
    clr_pulse();

    // Fan loss in RAMP: trip with empty cause
    ca_req_i = 1'b1;
    step();
    fan_on_i = 1'b0;
    step();
    chk("fan_trip", 32'(trip_o), 32'd1);
    chk("fan_ff", 32'(first_fault_o), 32'h000);
    fan_on_i = 1'b1; ca_req_i = 1'b0;
    clr_pulse();
    chk("fan_clr", 32'(state_o), 32'd0);

    // Reset mid-RAMP, after loading a cause
    go_run();
    u_low_i = 1'b1;
    step();
    u_low_i = 1'b0; ca_req_i = 1'b0;
    clr_pulse();
    ca_req_i = 1'b1;
    step(); step();
    chk("pre_rst_cnt", 32'(u_dut.u_cnt.count), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_cnt", 32'(u_dut.u_cnt.count), 32'd0);
    chk("mid_rst_outs", {29'd0, ca_on_o, ca_ok_o, trip_o}, 32'd0);
    chk("mid_rst_ff", 32'(first_fault_o), 32'd0);
    reset = 1'b0; ca_req_i = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
